// File: rtl/serial_modulo_n_fsm.sv
// rtl/serial_modulo_n_fsm.sv - serial MSB-first remainder/divisibility checker
// Tracks the number's value mod DIVISOR, DIGIT_W bits per accepted beat, with framing and a held result.
module serial_modulo_n_fsm #(
    parameter  int DIVISOR = 5,
    parameter  int DIGIT_W = 1,
    parameter  int CNT_W   = 16,
    localparam int REM_W   = $clog2(DIVISOR)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_first,
    input  logic               in_last,
    input  logic [DIGIT_W-1:0] in_digit,
    output logic [REM_W-1:0]   rem,
    output logic               div_by_n,
    output logic               out_valid,
    output logic               done,
    output logic [CNT_W-1:0]   digit_cnt
);

    localparam int EXT_W = REM_W + DIGIT_W;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } state_t;

    state_t           r_state;
    logic [REM_W-1:0] r_rem;
    logic             r_out_valid;
    logic             r_done;
    logic [CNT_W-1:0] r_cnt;

    logic             w_restart;
    logic [REM_W-1:0] w_base;
    logic [EXT_W-1:0] w_ext;
    logic [EXT_W-1:0] w_mod;
    logic [REM_W-1:0] w_next_rem;
    logic [CNT_W-1:0] w_next_cnt;

    // Outside RUN every accepted beat begins a new number, even without in_first.
    assign w_restart = in_first || (r_state != RUN);
    assign w_base    = w_restart ? '0 : r_rem;

    // {base, digit} is base*2^DIGIT_W + digit at full width, so the reduction is exact.
    assign w_ext      = {w_base, in_digit};
    assign w_mod      = w_ext % EXT_W'(DIVISOR);
    assign w_next_rem = REM_W'(w_mod);

    assign w_next_cnt = w_restart     ? CNT_W'(1) :
                        (r_cnt == '1) ? r_cnt     :
                                        r_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rem       <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_out_valid <= in_valid;
            r_done      <= in_valid && in_last;
            if (in_valid) begin
                r_rem   <= w_next_rem;
                r_cnt   <= w_next_cnt;
                r_state <= in_last ? HOLD : RUN;
            end
        end
    end

    assign rem       = r_rem;
    assign div_by_n  = (r_rem == '0);
    assign out_valid = r_out_valid;
    assign done      = r_done;
    assign digit_cnt = r_cnt;

endmodule

// File: tb/tb_serial_modulo_n_fsm.sv
// tb/tb_serial_modulo_n_fsm.sv - directed and scoreboard checks for serial_modulo_n_fsm
module tb_serial_modulo_n_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_first = 1'b0;
    logic       in_last = 1'b0;
    logic [7:0] in_digit = 8'd0;

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // DIVISOR=5, DIGIT_W=1
    logic [2:0]  a5_rem;
    logic        a5_div, a5_ov, a5_done;
    logic [15:0] a5_cnt;
    serial_modulo_n_fsm #(.DIVISOR(5), .DIGIT_W(1), .CNT_W(16)) u5 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .in_digit(in_digit[0:0]), .rem(a5_rem), .div_by_n(a5_div), .out_valid(a5_ov),
        .done(a5_done), .digit_cnt(a5_cnt));

    // DIVISOR=3, DIGIT_W=4
    logic [1:0]  a3_rem;
    logic        a3_div, a3_ov, a3_done;
    logic [15:0] a3_cnt;
    serial_modulo_n_fsm #(.DIVISOR(3), .DIGIT_W(4), .CNT_W(16)) u3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .in_digit(in_digit[3:0]), .rem(a3_rem), .div_by_n(a3_div), .out_valid(a3_ov),
        .done(a3_done), .digit_cnt(a3_cnt));

    // DIVISOR=7, DIGIT_W=2
    logic [2:0]  a7_rem;
    logic        a7_div, a7_ov, a7_done;
    logic [15:0] a7_cnt;
    serial_modulo_n_fsm #(.DIVISOR(7), .DIGIT_W(2), .CNT_W(16)) u7 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .in_digit(in_digit[1:0]), .rem(a7_rem), .div_by_n(a7_div), .out_valid(a7_ov),
        .done(a7_done), .digit_cnt(a7_cnt));

    // DIVISOR=5, DIGIT_W=1, CNT_W=3 for saturation
    logic [2:0] as_rem;
    logic       as_div, as_ov, as_done;
    logic [2:0] as_cnt;
    serial_modulo_n_fsm #(.DIVISOR(5), .DIGIT_W(1), .CNT_W(3)) usat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .in_digit(in_digit[0:0]), .rem(as_rem), .div_by_n(as_div), .out_valid(as_ov),
        .done(as_done), .digit_cnt(as_cnt));

    // Grid of DIGIT_W 1..8 x DIVISOR 2..13 sharing one input stream
    logic [7:0]  g_rem  [1:8][2:13];
    logic        g_div  [1:8][2:13];
    logic        g_ov   [1:8][2:13];
    logic        g_done [1:8][2:13];
    logic [15:0] g_cnt  [1:8][2:13];

    for (genvar gd = 1; gd <= 8; gd++) begin : g_dw
        for (genvar gk = 2; gk <= 13; gk++) begin : g_dv
            localparam int RW = $clog2(gk);
            logic [RW-1:0] w_rem;
            serial_modulo_n_fsm #(.DIVISOR(gk), .DIGIT_W(gd), .CNT_W(16)) u_g (
                .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
                .in_digit(in_digit[gd-1:0]), .rem(w_rem), .div_by_n(g_div[gd][gk]),
                .out_valid(g_ov[gd][gk]), .done(g_done[gd][gk]), .digit_cnt(g_cnt[gd][gk]));
            assign g_rem[gd][gk] = 8'(w_rem);
        end
    end

    // Drive one beat at the falling edge; returns at the next falling edge with outputs updated.
    task automatic step(input logic v, input logic f, input logic l, input logic [7:0] d);
        in_valid = v;
        in_first = f;
        in_last  = l;
        in_digit = d;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 8'd0);
        rst = 1'b0;
    endtask

    int         ov_count;
    int         m_sat_rem;
    int         ref_rem [1:8][2:13];
    int         m_st;
    int         m_cnt;
    logic       rv, rf, rl, rs;
    logic [7:0] rd;

    initial begin
        @(negedge clk);
        do_reset();

        // Reset state
        check("rst_rem",  32'(a5_rem), 0);
        check("rst_div",  32'(a5_div), 1);
        check("rst_ov",   32'(a5_ov),  0);
        check("rst_done", 32'(a5_done), 0);
        check("rst_cnt",  32'(a5_cnt), 0);

        // 1010b = 10 mod 5
        step(1, 1, 0, 8'd1);
        check("t1_rem1", 32'(a5_rem), 1); check("t1_div1", 32'(a5_div), 0);
        check("t1_ov1", 32'(a5_ov), 1);   check("t1_done1", 32'(a5_done), 0);
        step(1, 0, 0, 8'd0);
        check("t1_rem2", 32'(a5_rem), 2); check("t1_div2", 32'(a5_div), 0);
        check("t1_done2", 32'(a5_done), 0);
        step(1, 0, 0, 8'd1);
        check("t1_rem3", 32'(a5_rem), 0); check("t1_div3", 32'(a5_div), 1);
        check("t1_done3", 32'(a5_done), 0);
        step(1, 0, 1, 8'd0);
        check("t1_rem4", 32'(a5_rem), 0); check("t1_div4", 32'(a5_div), 1);
        check("t1_done4", 32'(a5_done), 1); check("t1_cnt4", 32'(a5_cnt), 4);
        step(0, 0, 0, 8'd0);
        check("t1_ov_idle", 32'(a5_ov), 0); check("t1_done_idle", 32'(a5_done), 0);

        // 0x12 = 18 mod 3, then held in HOLD with stray first/last while invalid
        do_reset();
        step(1, 1, 0, 8'h1);
        check("t2_rem1", 32'(a3_rem), 1);
        step(1, 0, 1, 8'h2);
        check("t2_rem2", 32'(a3_rem), 0); check("t2_done", 32'(a3_done), 1);
        for (int i = 0; i < 10; i++) begin
            step(0, i[0], i[1], 8'hF);
            check("t2_hold_rem", 32'(a3_rem), 0); check("t2_hold_div", 32'(a3_div), 1);
            check("t2_hold_ov", 32'(a3_ov), 0);
        end
        check("t2_hold_cnt", 32'(a3_cnt), 2);

        // 3,1,2 base 4 = 54 mod 7, with 3-cycle gaps
        do_reset();
        ov_count = 0;
        step(1, 1, 0, 8'd3);
        ov_count += int'(a7_ov);
        check("t3_rem1", 32'(a7_rem), 3);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 8'd2);
            ov_count += int'(a7_ov);
            check("t3_gap1_rem", 32'(a7_rem), 3);
        end
        step(1, 0, 0, 8'd1);
        ov_count += int'(a7_ov);
        check("t3_rem2", 32'(a7_rem), 6);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 8'd3);
            ov_count += int'(a7_ov);
            check("t3_gap2_rem", 32'(a7_rem), 6);
        end
        step(1, 0, 1, 8'd2);
        ov_count += int'(a7_ov);
        check("t3_rem3", 32'(a7_rem), 5); check("t3_div3", 32'(a7_div), 0);
        check("t3_done", 32'(a7_done), 1); check("t3_cnt", 32'(a7_cnt), 3);
        step(0, 0, 0, 8'd0);
        ov_count += int'(a7_ov);
        check("t3_ov_count", 32'(ov_count), 3);

        // Restart mid-number, then implicit restart from HOLD
        do_reset();
        step(1, 1, 0, 8'd1);
        check("t4_rem1", 32'(a5_rem), 1); check("t4_cnt1", 32'(a5_cnt), 1);
        step(1, 0, 0, 8'd1);
        check("t4_rem2", 32'(a5_rem), 3); check("t4_cnt2", 32'(a5_cnt), 2);
        step(1, 1, 0, 8'd1);
        check("t4_rem3", 32'(a5_rem), 1); check("t4_cnt3", 32'(a5_cnt), 1);
        check("t4_done3", 32'(a5_done), 0);
        step(1, 0, 1, 8'd0);
        check("t4_rem4", 32'(a5_rem), 2); check("t4_done4", 32'(a5_done), 1);
        step(1, 0, 0, 8'd1);
        check("t4_hold_restart_rem", 32'(a5_rem), 1);
        check("t4_hold_restart_cnt", 32'(a5_cnt), 1);
        check("t4_hold_restart_done", 32'(a5_done), 0);

        // Reset mid-number drops the coincident beat
        do_reset();
        step(1, 1, 0, 8'd1);
        step(1, 0, 0, 8'd1);
        check("t5_pre_rem", 32'(a5_rem), 3);
        rst = 1'b1;
        step(1, 0, 0, 8'd1);
        rst = 1'b0;
        check("t5_rem", 32'(a5_rem), 0); check("t5_div", 32'(a5_div), 1);
        check("t5_cnt", 32'(a5_cnt), 0); check("t5_ov", 32'(a5_ov), 0);
        step(1, 0, 0, 8'd1);
        check("t5_next_rem", 32'(a5_rem), 1); check("t5_next_cnt", 32'(a5_cnt), 1);

        // Counter saturation at 7 with rem = (2^k-1) mod 5
        do_reset();
        m_sat_rem = 0;
        for (int k = 1; k <= 10; k++) begin
            step(1, k == 1, 0, 8'd1);
            m_sat_rem = (m_sat_rem * 2 + 1) % 5;
            check($sformatf("t6_rem_k%0d", k), 32'(as_rem), 32'(m_sat_rem));
            check($sformatf("t6_cnt_k%0d", k), 32'(as_cnt), 32'((k > 7) ? 7 : k));
            check($sformatf("t6_div_k%0d", k), 32'(as_div), 32'(m_sat_rem == 0));
        end

        // Scoreboard across the parameter grid
        do_reset();
        m_st  = 0;
        m_cnt = 0;
        for (int d = 1; d <= 8; d++)
            for (int k = 2; k <= 13; k++)
                ref_rem[d][k] = 0;
        for (int it = 0; it < 30; it++) begin
            rv = ($urandom_range(0, 3) != 0);
            rf = ($urandom_range(0, 5) == 0);
            rl = ($urandom_range(0, 4) == 0);
            rd = 8'($urandom);
            if (rv) begin
                rs = rf || (m_st != 1);
                for (int d = 1; d <= 8; d++)
                    for (int k = 2; k <= 13; k++)
                        ref_rem[d][k] = ((rs ? 0 : ref_rem[d][k]) * (1 << d)
                                         + (int'(rd) & ((1 << d) - 1))) % k;
                m_cnt = rs ? 1 : m_cnt + 1;
                m_st  = rl ? 2 : 1;
            end
            step(rv, rf, rl, rd);
            for (int d = 1; d <= 8; d++) begin
                for (int k = 2; k <= 13; k++) begin
                    check($sformatf("g_rem_d%0d_n%0d_i%0d", d, k, it), 32'(g_rem[d][k]), 32'(ref_rem[d][k]));
                    check($sformatf("g_div_d%0d_n%0d_i%0d", d, k, it), 32'(g_div[d][k]), 32'(ref_rem[d][k] == 0));
                    check($sformatf("g_ov_d%0d_n%0d_i%0d", d, k, it), 32'(g_ov[d][k]), 32'(rv));
                    check($sformatf("g_done_d%0d_n%0d_i%0d", d, k, it), 32'(g_done[d][k]), 32'(rv && rl));
                    check($sformatf("g_cnt_d%0d_n%0d_i%0d", d, k, it), 32'(g_cnt[d][k]), 32'(m_cnt));
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
